// File: rtl/ssd_scan_mux.sv
`timescale 1ns/1ps
// ssd_scan_mux
//   Time-multiplexing scanner for an 8-digit seven-segment display. It sits
//   directly upstream of the per-digit segment decoder.
//
//   Each digit slot is lit for DIV cycles (SHOW). A BLANK_CYC-cycle dark gap
//   (BLANK) follows to prevent ghosting. A frame is 8 slots long.
//
//   New content arrives through a valid/ready handshake into a pending bank.
//   It is copied into the active bank only on the BLANK(7) -> SHOW(0) edge,
//   so a frame never mixes old and new data.
//
// Parameters
//   DIV        cycles each digit is lit per slot (>= 2)
//   BLANK_CYC  cycles of blanking after each digit (>= 1)
//
// Ports
//   ssd_scan_port_clk         in   system clock
//   ssd_scan_port_rst_n       in   asynchronous active-low reset
//   ssd_scan_port_digits_in   in   digit i code at bits [5i+4:5i]
//   ssd_scan_port_dp_in       in   decimal-point request per digit, 1 = lit
//   ssd_scan_port_en_in       in   digit enable mask, 1 = digit shown
//   ssd_scan_port_load_valid  in   load request
//   ssd_scan_port_load_ready  out  block can accept a load
//   ssd_scan_port_code_out    out  code for the decoder, 5'h1F = blank
//   ssd_scan_port_dp_out      out  decimal point, active-low
//   ssd_scan_port_an_out      out  anodes, active-low, at most one bit low
//   ssd_scan_port_frame_out   out  one-cycle pulse on each frame boundary
module ssd_scan_mux #(
    parameter int unsigned DIV       = 100000,
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        ssd_scan_port_clk,
    input  logic        ssd_scan_port_rst_n,
    input  logic [39:0] ssd_scan_port_digits_in,
    input  logic [7:0]  ssd_scan_port_dp_in,
    input  logic [7:0]  ssd_scan_port_en_in,
    input  logic        ssd_scan_port_load_valid,
    output logic        ssd_scan_port_load_ready,
    output logic [4:0]  ssd_scan_port_code_out,
    output logic        ssd_scan_port_dp_out,
    output logic [7:0]  ssd_scan_port_an_out,
    output logic        ssd_scan_port_frame_out
);

    localparam int unsigned CntMax = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] ShowLast  = CntW'(DIV - 1);
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);

    localparam logic [39:0] DigitsBlank = {8{5'h1F}};
    localparam logic [4:0]  CodeBlank   = 5'h1F;

    typedef enum logic {
        StShow,
        StBlank
    } state_e;

    // Scan sequencer
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            boundary;

    // Active and pending display banks
    logic [39:0] act_dig_q, act_dig_d;
    logic [7:0]  act_dp_q, act_dp_d;
    logic [7:0]  act_en_q, act_en_d;
    logic [39:0] pend_dig_q, pend_dig_d;
    logic [7:0]  pend_dp_q, pend_dp_d;
    logic [7:0]  pend_en_q, pend_en_d;
    logic        pend_q, pend_d;
    logic        ready_q, ready_d;
    logic        xfer;
    logic        commit;

    // Registered outputs
    logic [7:0] an_q, an_d;
    logic [4:0] code_q, code_d;
    logic       dp_q, dp_d;
    logic       frame_q, frame_d;
    logic [4:0] code_sel;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            state_q <= StShow;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntW'(1);
        idx_d    = idx_q;
        boundary = 1'b0;
        unique case (state_q)
            StShow: begin
                if (cnt_q == ShowLast) begin
                    state_d = StBlank;
                    cnt_d   = '0;
                end
            end
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d  = StShow;
                    cnt_d    = '0;
                    // The 3-bit index wraps 7 -> 0 by itself.
                    idx_d    = idx_q + 3'd1;
                    boundary = (idx_q == 3'd7);
                end
            end
            default: begin
                state_d = StShow;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load handshake and frame-boundary commit
    // ------------------------------------------------------------------
    always_comb begin
        xfer   = ssd_scan_port_load_valid && ready_q;
        // Only data that was already pending before this edge commits. A load
        // taken on the boundary edge itself waits for the next boundary.
        commit = boundary && pend_q;

        act_dig_d  = act_dig_q;
        act_dp_d   = act_dp_q;
        act_en_d   = act_en_q;
        pend_dig_d = pend_dig_q;
        pend_dp_d  = pend_dp_q;
        pend_en_d  = pend_en_q;
        pend_d     = pend_q;

        if (commit) begin
            act_dig_d = pend_dig_q;
            act_dp_d  = pend_dp_q;
            act_en_d  = pend_en_q;
            pend_d    = 1'b0;
        end

        // xfer requires ready, so pend_q is clear and commit cannot also fire.
        if (xfer) begin
            pend_dig_d = ssd_scan_port_digits_in;
            pend_dp_d  = ssd_scan_port_dp_in;
            pend_en_d  = ssd_scan_port_en_in;
            pend_d     = 1'b1;
        end

        ready_d = ~pend_d;
    end

    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            act_dig_q  <= DigitsBlank;
            act_dp_q   <= 8'h00;
            act_en_q   <= 8'h00;
            pend_dig_q <= DigitsBlank;
            pend_dp_q  <= 8'h00;
            pend_en_q  <= 8'h00;
            pend_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            act_dig_q  <= act_dig_d;
            act_dp_q   <= act_dp_d;
            act_en_q   <= act_en_d;
            pend_dig_q <= pend_dig_d;
            pend_dp_q  <= pend_dp_d;
            pend_en_q  <= pend_en_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // The outputs are decoded from the next state and the next active bank.
    // The registered outputs therefore change on the same edge as the slot.
    // This includes the first digit of a newly committed frame.
    // ------------------------------------------------------------------
    always_comb begin
        code_sel = CodeBlank;
        for (int i = 0; i < 8; i++) begin
            if (idx_d == 3'(i)) begin
                code_sel = act_dig_d[5*i +: 5];
            end
        end

        an_d    = 8'hFF;
        code_d  = CodeBlank;
        dp_d    = 1'b1;
        frame_d = boundary;

        // A disabled digit stays dark for its whole slot and is not skipped.
        if ((state_d == StShow) && act_en_d[idx_d]) begin
            an_d   = ~(8'b0000_0001 << idx_d);
            code_d = code_sel;
            dp_d   = ~act_dp_d[idx_d];
        end
    end

    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            an_q    <= 8'hFF;
            code_q  <= CodeBlank;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            an_q    <= an_d;
            code_q  <= code_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign ssd_scan_port_an_out     = an_q;
    assign ssd_scan_port_code_out   = code_q;
    assign ssd_scan_port_dp_out     = dp_q;
    assign ssd_scan_port_frame_out  = frame_q;
    assign ssd_scan_port_load_ready = ready_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
`timescale 1ns/1ps
// Self-checking bench for ssd_scan_mux with DIV = 4 and BLANK_CYC = 2 (48-cycle frame).
// The reference model derives the outputs from the elapsed cycle count since
// reset release plus the active and pending banks.
module tb_ssd_scan_mux;

    localparam int DIV   = 4;
    localparam int BLK   = 2;
    localparam int SLOT  = DIV + BLK;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [39:0] digits_in = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  en_in = '0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [4:0]  code_out;
    logic        dp_out;
    logic [7:0]  an_out;
    logic        frame_out;

    always #5 clk = ~clk;

    ssd_scan_mux #(
        .DIV       (DIV),
        .BLANK_CYC (BLK)
    ) dut (
        .ssd_scan_port_clk        (clk),
        .ssd_scan_port_rst_n      (rst_n),
        .ssd_scan_port_digits_in  (digits_in),
        .ssd_scan_port_dp_in      (dp_in),
        .ssd_scan_port_en_in      (en_in),
        .ssd_scan_port_load_valid (load_valid),
        .ssd_scan_port_load_ready (load_ready),
        .ssd_scan_port_code_out   (code_out),
        .ssd_scan_port_dp_out     (dp_out),
        .ssd_scan_port_an_out     (an_out),
        .ssd_scan_port_frame_out  (frame_out)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int          m_t;
    bit          m_frame;
    bit          m_pend;
    logic [39:0] m_act_dig, m_pend_dig;
    logic [7:0]  m_act_dp, m_act_en, m_pend_dp, m_pend_en;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, got, exp, m_t,
                     $time);
        end
    endtask

    function automatic void model_reset();
        m_t        = 0;
        m_frame    = 1'b0;
        m_pend     = 1'b0;
        m_act_dig  = {8{5'h1F}};
        m_pend_dig = {8{5'h1F}};
        m_act_dp   = 8'h00;
        m_act_en   = 8'h00;
        m_pend_dp  = 8'h00;
        m_pend_en  = 8'h00;
    endfunction

    // One rising edge: the bench inputs are the values the DUT sampled.
    function automatic void model_edge();
        bit xfer;
        xfer    = load_valid && !m_pend;
        m_t     = m_t + 1;
        m_frame = (m_t % FRAME) == 0;
        if (m_frame && m_pend) begin
            m_act_dig = m_pend_dig;
            m_act_dp  = m_pend_dp;
            m_act_en  = m_pend_en;
            m_pend    = 1'b0;
        end
        if (xfer) begin
            m_pend_dig = digits_in;
            m_pend_dp  = dp_in;
            m_pend_en  = en_in;
            m_pend     = 1'b1;
        end
    endfunction

    function automatic bit m_lit();
        int p;
        int s;
        p = m_t % FRAME;
        s = p / SLOT;
        return ((p % SLOT) < DIV) && m_act_en[s];
    endfunction

    function automatic logic [7:0] exp_an();
        logic [7:0] one;
        int s;
        one = 8'h01;
        s   = (m_t % FRAME) / SLOT;
        return m_lit() ? ~(one << s) : 8'hFF;
    endfunction

    function automatic logic [4:0] exp_code();
        int s;
        s = (m_t % FRAME) / SLOT;
        return m_lit() ? m_act_dig[5*s +: 5] : 5'h1F;
    endfunction

    function automatic logic exp_dp();
        int s;
        s = (m_t % FRAME) / SLOT;
        return m_lit() ? ~m_act_dp[s] : 1'b1;
    endfunction

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("an_out", an_out, exp_an());
            check("code_out", code_out, exp_code());
            check("dp_out", dp_out, exp_dp());
            check("load_ready", load_ready, !m_pend);
            check("frame_out", frame_out, m_frame);
        end
    end

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to_phase(input int ph);
        for (int i = 0; i < FRAME; i++) begin
            if ((m_t % FRAME) == ph) break;
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        ticks(2);
        rst_n = 1'b1;
    endtask

    function automatic logic [39:0] rand_digits();
        logic [39:0] d;
        for (int i = 0; i < 8; i++) d[5*i +: 5] = 5'($urandom_range(0, 31));
        return d;
    endfunction

    logic [39:0] dset;
    logic [4:0]  old_d0, new_d0;

    initial begin
        model_reset();
        chk_en = 1'b1;
        ticks(2);
        rst_n = 1'b1;

        // Reset idle
        check("rst_an", an_out, 8'hFF);
        check("rst_code", code_out, 5'h1F);
        check("rst_dp", dp_out, 1'b1);
        check("rst_ready", load_ready, 1'b1);
        check("rst_frame", frame_out, 1'b0);
        ticks(47);
        check("idle_frame47", frame_out, 1'b0);
        tick();
        check("idle_frame48", frame_out, 1'b1);
        ticks(48);
        check("idle_frame96", frame_out, 1'b1);
        check("idle_an96", an_out, 8'hFF);

        // Handshake and digit sequence
        do_reset();
        ticks(10);
        for (int i = 0; i < 8; i++) dset[5*i +: 5] = 5'(i);
        digits_in  = dset;
        en_in      = 8'hFF;
        dp_in      = 8'h01;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check("hs_ready11", load_ready, 1'b0);
        ticks(9);
        digits_in  = {8{5'h0A}};
        dp_in      = 8'hFF;
        load_valid = 1'b1;
        ticks(3);
        load_valid = 1'b0;
        ticks(48 - m_t);
        check("hs_frame48", frame_out, 1'b1);
        check("hs_ready48", load_ready, 1'b1);
        check("d0_an", an_out, 8'hFE);
        check("d0_code", code_out, 5'h00);
        check("d0_dp", dp_out, 1'b0);
        ticks(4);
        check("blank_an", an_out, 8'hFF);
        check("blank_code", code_out, 5'h1F);
        ticks(2);
        check("d1_an", an_out, 8'hFD);
        check("d1_code", code_out, 5'h01);
        check("d1_dp", dp_out, 1'b1);
        ticks(36);
        check("d7_an", an_out, 8'h7F);
        check("d7_code", code_out, 5'h07);

        // Enable mask 0000_0101
        old_d0     = 5'($urandom_range(0, 31));
        digits_in  = rand_digits();
        digits_in[4:0] = old_d0;
        dp_in      = 8'($urandom);
        en_in      = 8'b0000_0101;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        ticks(2 * FRAME);
        run_to_phase(2 * SLOT + 1);
        check("mask_an2", an_out, 8'hFB);
        ticks(SLOT);
        check("mask_an3", an_out, 8'hFF);

        // Load accepted exactly on the boundary edge
        run_to_phase(FRAME - 1);
        new_d0     = old_d0 ^ 5'h15;
        digits_in  = rand_digits();
        digits_in[4:0] = new_d0;
        en_in      = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check("edge_frame", frame_out, 1'b1);
        check("edge_ready", load_ready, 1'b0);
        check("edge_old_code", code_out, 32'(old_d0));
        ticks(FRAME);
        check("edge_frame2", frame_out, 1'b1);
        check("edge_new_code", code_out, 32'(new_d0));
        check("edge_ready2", load_ready, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            load_valid = ($urandom_range(0, 19) == 0);
            digits_in  = rand_digits();
            dp_in      = 8'($urandom);
            en_in      = 8'($urandom);
            tick();
        end
        load_valid = 1'b0;
        ticks(FRAME);

        // Asynchronous reset mid-SHOW of digit 3 with a load pending
        run_to_phase(10);
        digits_in  = rand_digits();
        dp_in      = 8'hFF;
        en_in      = 8'hFF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        run_to_phase(3 * SLOT + 1);
        check("pre_rst_ready", load_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_an", an_out, 8'hFF);
        check("arst_code", code_out, 5'h1F);
        check("arst_dp", dp_out, 1'b1);
        check("arst_ready", load_ready, 1'b1);
        check("arst_frame", frame_out, 1'b0);
        ticks(2);
        rst_n = 1'b1;
        ticks(FRAME + 3 * SLOT + 1);
        check("post_rst_an", an_out, 8'hFF);
        ticks(FRAME);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
